// File: rtl/audio_fifo_wr_arbiter_if.sv
// Write-port bundle shared by the audio FIFO write arbiter and its sample sources.
// The slave side is the arbiter; the master side is the sources plus the FIFO full flag.
interface audio_fifo_wr_arbiter_if #(
   parameter int req_n      = 2,
   parameter int data_width = 32
);
   logic [req_n*data_width-1:0] s_data;
   logic [req_n-1:0]            s_valid;
   logic [req_n-1:0]            s_last;
   logic [req_n-1:0]            s_ready;
   logic                        fifo_wen;
   logic                        fifo_full;
   logic [data_width-1:0]       fifo_din;

   modport master (
      output s_data, s_valid, s_last, fifo_full,
      input  s_ready, fifo_wen, fifo_din
   );

   modport slave (
      input  s_data, s_valid, s_last, fifo_full,
      output s_ready, fifo_wen, fifo_din
   );
endinterface

// File: rtl/audio_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the audio FIFO write port among req_n sources.
// Optional stall counter: define AUDIO_FIFO_WR_ARB_STALL_CNT_EN.
module audio_fifo_wr_arbiter #(
   parameter int req_n            = 2,
   parameter int data_width       = 32,
   parameter int max_burst        = 8,
   parameter int simulation_delay = 1
) (
   input  logic                          clk_wt,
   input  logic                          rst_n_wt,
   input  logic                          arb_en,
   audio_fifo_wr_arbiter_if.slave        bus,
   output logic [$clog2(req_n-1):0]      grant_id,
   output logic                          busy
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                   stall_cnt,
   input  logic                          stall_clr
`endif
);
   localparam int GW = $clog2(req_n-1) + 1;
   localparam int CW = $clog2(max_burst-1) + 1;

   // Empty guard block: flags an out-of-range configuration in elaboration listings.
   if (req_n < 2 || req_n > 8 || max_burst < 1 || max_burst > 256 || simulation_delay < 0) begin : g_param_out_of_range
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [req_n-1:0] sel;
   logic            g_valid;
   logic            g_last;
   logic [2*req_n-1:0] dbl;
   logic [req_n-1:0]   rot;
   logic [GW-1:0]      win;

   generate
      for (genvar gi = 0; gi < req_n; gi++) begin : g_sel
         assign sel[gi]         = (state_q == GRANT) && (grant_q == GW'(gi));
         assign bus.s_ready[gi] = sel[gi] & ~bus.fifo_full;
      end
   endgenerate

   always_comb begin
      g_valid      = 1'b0;
      g_last       = 1'b0;
      bus.fifo_din = '0;
      for (int i = 0; i < req_n; i++) begin
         if (sel[i]) begin
            g_valid      = bus.s_valid[i];
            g_last       = bus.s_last[i];
            bus.fifo_din = bus.s_data[i*data_width +: data_width];
         end
      end
   end

   assign bus.fifo_wen = g_valid & ~bus.fifo_full;

   // Rotate requests so bit 0 is the requester just after the previous winner.
   assign dbl = {bus.s_valid, bus.s_valid};
   assign rot = req_n'(dbl >> (int'(last_q) + 1));

   always_comb begin
      int jsel;
      jsel = 0;
      for (int j = req_n - 1; j >= 0; j--) begin
         if (rot[j]) jsel = j;
      end
      win = GW'((int'(last_q) + 1 + jsel) % req_n);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (arb_en && (|bus.s_valid)) begin
               state_d = GRANT;
               grant_d = win;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (bus.fifo_wen) begin
               if (g_last || cnt_q == CW'(max_burst - 1)) begin
                  state_d = IDLE;
                  last_d  = grant_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_wt or negedge rst_n_wt) begin
      if (!rst_n_wt) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(req_n - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == GRANT);

`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Clear takes priority over a same-cycle stall increment.
   always_comb begin
      stall_d = stall_q;
      if (stall_clr) begin
         stall_d = '0;
      end else if (g_valid && bus.fifo_full && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_wt or negedge rst_n_wt) begin
      if (!rst_n_wt) stall_q <= '0;
      else           stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_audio_fifo_wr_arbiter.sv
// Scoreboard bench for audio_fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference of the arbitration rules.
module tb_audio_fifo_wr_arbiter;
   localparam int REQ_N     = 2;
   localparam int DW        = 32;
   localparam int MAX_BURST = 8;
   localparam int GW        = $clog2(REQ_N-1) + 1;

   logic          clk_wt   = 1'b0;
   logic          rst_n_wt = 1'b0;
   logic          arb_en   = 1'b0;
   logic [GW-1:0] grant_id;
   logic          busy;
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0]   stall_cnt;
   logic          stall_clr = 1'b0;
   logic [15:0]   m_stall;
`endif

   audio_fifo_wr_arbiter_if #(.req_n(REQ_N), .data_width(DW)) bus ();

   audio_fifo_wr_arbiter #(
      .req_n(REQ_N), .data_width(DW), .max_burst(MAX_BURST), .simulation_delay(1)
   ) dut (
      .clk_wt   (clk_wt),
      .rst_n_wt (rst_n_wt),
      .arb_en   (arb_en),
      .bus      (bus.slave),
      .grant_id (grant_id),
      .busy     (busy)
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt),
      .stall_clr(stall_clr)
`endif
   );

   always #5 clk_wt = ~clk_wt;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [GW-1:0] g;
      logic [15:0]   len;
   } burst_t;

   beat_t         src_q[REQ_N][$];
   logic [DW-1:0] exp_q[REQ_N][$];
   burst_t        log_q[$];

   int n_cmp    = 0;
   int n_err    = 0;
   int wr_total = 0;
   int gap_pct  = 0;

   logic          m_busy;
   logic [GW-1:0] m_grant;
   logic [GW-1:0] m_last;
   int            m_cnt;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Closest requester after 'last' in circular order.
   function automatic logic [GW-1:0] pick(logic [REQ_N-1:0] v, logic [GW-1:0] last);
      int best_d = REQ_N + 1;
      int best   = 0;
      for (int i = 0; i < REQ_N; i++) begin
         int d = (i - int'(last) - 1 + 2*REQ_N) % REQ_N;
         if (v[i] && d < best_d) begin
            best_d = d;
            best   = i;
         end
      end
      return GW'(best);
   endfunction

   task automatic push_burst(int src, int n, logic [DW-1:0] base);
      for (int k = 0; k < n; k++) begin
         beat_t b;
         b.data = base + DW'(k);
         b.last = (k == n - 1);
         src_q[src].push_back(b);
         exp_q[src].push_back(b.data);
      end
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(posedge clk_wt);
      #1;
   endtask

   task automatic wait_writes(int n, int budget);
      int target = wr_total + n;
      int t = 0;
      while (wr_total < target && t < budget) begin
         wait_cycles(1);
         t++;
      end
      if (wr_total < target) check("wait_writes_timeout", 64'(wr_total), 64'(target));
   endtask

   function automatic bit all_idle();
      bit r = !m_busy;
      for (int i = 0; i < REQ_N; i++)
         if (src_q[i].size() != 0 || exp_q[i].size() != 0) r = 0;
      return r;
   endfunction

   task automatic wait_drained(int budget);
      int t = 0;
      while (!all_idle() && t < budget) begin
         wait_cycles(1);
         t++;
      end
      check("drain_timeout", 64'(all_idle()), 64'd1);
   endtask

   task automatic check_log(int idx, int g, int len);
      if (idx < log_q.size()) begin
         check("burst_grant", 64'(log_q[idx].g), 64'(g));
         check("burst_len", 64'(log_q[idx].len), 64'(len));
      end else begin
         check("burst_present", 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   // Source driver: retires handshaken beats, then presents the next head of each queue.
   initial begin
      logic [REQ_N-1:0] hs;
      bus.s_valid = '0;
      bus.s_last  = '0;
      bus.s_data  = '0;
      forever begin
         @(negedge clk_wt);
         hs = bus.s_valid & bus.s_ready & {REQ_N{rst_n_wt}};
         @(posedge clk_wt);
         #1;
         for (int i = 0; i < REQ_N; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
               bus.s_valid[i]             = 1'b1;
               bus.s_last[i]              = src_q[i][0].last;
               bus.s_data[i*DW +: DW]     = src_q[i][0].data;
            end else begin
               bus.s_valid[i]             = 1'b0;
               bus.s_last[i]              = 1'b0;
               bus.s_data[i*DW +: DW]     = DW'($urandom);
            end
         end
      end
   end

   // Monitor and reference model, evaluated mid-cycle.
   initial begin
      m_busy = 0; m_grant = '0; m_last = GW'(REQ_N-1); m_cnt = 0;
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
      m_stall = '0;
`endif
      forever begin
         logic [REQ_N-1:0] er;
         logic             vg, ew;
         @(negedge clk_wt);
         if (!rst_n_wt) begin
            m_busy = 0; m_grant = '0; m_last = GW'(REQ_N-1); m_cnt = 0;
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
            m_stall = '0;
`endif
            continue;
         end
         vg = m_busy && bus.s_valid[m_grant];
         ew = vg && !bus.fifo_full;
         er = '0;
         if (m_busy && !bus.fifo_full) er[m_grant] = 1'b1;
         check("busy", 64'(busy), 64'(m_busy));
         if (m_busy) check("grant_id", 64'(grant_id), 64'(m_grant));
         check("s_ready", 64'(bus.s_ready), 64'(er));
         check("fifo_wen", 64'(bus.fifo_wen), 64'(ew));
         if (ew) begin
            if (exp_q[m_grant].size() == 0) begin
               check("beat_expected", 64'd0, 64'd1);
            end else begin
               check("fifo_din", 64'(bus.fifo_din), 64'(exp_q[m_grant].pop_front()));
            end
            wr_total++;
         end
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         if (stall_clr) m_stall = '0;
         else if (vg && bus.fifo_full && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
         if (m_busy) begin
            if (ew) begin
               m_cnt++;
               if (bus.s_last[m_grant] || m_cnt == MAX_BURST) begin
                  log_q.push_back({m_grant, 16'(m_cnt)});
                  $display("burst src=%0d beats=%0d t=%0t", m_grant, m_cnt, $time);
                  m_busy = 0;
                  m_last = m_grant;
               end
            end
         end else if (arb_en && (|bus.s_valid)) begin
            m_busy  = 1;
            m_grant = pick(bus.s_valid, m_last);
            m_cnt   = 0;
         end
      end
   end

   initial begin
      int base;
      bus.fifo_full = 1'b0;
      #1;
      check("rst_s_ready", 64'(bus.s_ready), 64'd0);
      check("rst_fifo_wen", 64'(bus.fifo_wen), 64'd0);
      check("rst_fifo_din", 64'(bus.fifo_din), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      wait_cycles(3);
      rst_n_wt = 1'b1;
      arb_en   = 1'b1;

      // Round robin between two continuously valid sources
      base = log_q.size();
      push_burst(0, 2, 32'h100); push_burst(0, 2, 32'h110);
      push_burst(1, 2, 32'h200); push_burst(1, 2, 32'h210);
      wait_drained(200);
      check_log(base, 0, 2); check_log(base+1, 1, 2);
      check_log(base+2, 0, 2); check_log(base+3, 1, 2);

      // Single requester, 4 beats
      base = log_q.size();
      push_burst(0, 4, 32'hA0);
      wait_drained(100);
      check_log(base, 0, 4);
      check("single_grant_id_hold", 64'(grant_id), 64'd0);

      // Max-burst cut with requester 0 joining mid-burst
      base = log_q.size();
      push_burst(1, 20, 32'h300);
      wait_writes(3, 100);
      push_burst(0, 2, 32'h400);
      wait_drained(300);
      check_log(base, 1, 8); check_log(base+1, 0, 2);
      check_log(base+2, 1, 8); check_log(base+3, 1, 4);

      // FIFO full backpressure for 5 cycles after beat 2
      base = log_q.size();
      push_burst(0, 6, 32'h500);
      wait_writes(3, 100);
      bus.fifo_full = 1'b1;
      wait_cycles(5);
      bus.fifo_full = 1'b0;
      wait_drained(100);
      check_log(base, 0, 6);
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
      check("stall_cnt_five", 64'(stall_cnt), 64'd5);
      stall_clr = 1'b1;
      wait_cycles(1);
      stall_clr = 1'b0;
      check("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
`endif

      // arb_en dropped during a burst
      base = log_q.size();
      push_burst(0, 4, 32'h600);
      wait_writes(1, 100);
      arb_en = 1'b0;
      push_burst(0, 2, 32'h610);
      push_burst(1, 2, 32'h620);
      wait_cycles(15);
      check("arb_off_bursts", 64'(log_q.size()), 64'(base + 1));
      check_log(base, 0, 4);
      check("arb_off_busy", 64'(busy), 64'd0);
      arb_en = 1'b1;
      wait_drained(200);
      check_log(base+1, 1, 2); check_log(base+2, 0, 2);

      // Reset mid-burst
      push_burst(0, 4, 32'h700);
      wait_writes(2, 100);
      #2 rst_n_wt = 1'b0;
      #1;
      check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
      check("mid_rst_fifo_wen", 64'(bus.fifo_wen), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      for (int i = 0; i < REQ_N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      wait_cycles(2);
      base = log_q.size();
      push_burst(0, 2, 32'h710);
      push_burst(1, 2, 32'h720);
      wait_cycles(1);
      rst_n_wt = 1'b1;
      wait_drained(200);
      check_log(base, 0, 2); check_log(base+1, 1, 2);

      // Randomized traffic
      gap_pct = 20;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < REQ_N; i++)
            if (src_q[i].size() < 16 && $urandom_range(3) == 0)
               push_burst(i, int'($urandom_range(1, 12)), DW'($urandom));
         arb_en        = ($urandom_range(9) != 0);
         bus.fifo_full = ($urandom_range(4) == 0);
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
         stall_clr     = ($urandom_range(29) == 0);
`endif
         wait_cycles(1);
      end
      bus.fifo_full = 1'b0;
      arb_en        = 1'b1;
      gap_pct       = 0;
`ifdef AUDIO_FIFO_WR_ARB_STALL_CNT_EN
      stall_clr     = 1'b0;
`endif
      wait_drained(3000);
      for (int i = 0; i < REQ_N; i++)
         check("leftover_beats", 64'(exp_q[i].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
